fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch front end for the MIPS core. Owns the program counter, drives the combinational instruction memory, and buffers fetched words with their PCs in a DEPTH-entry queue. Decode consumes the queue through a valid/ready handshake. Resolves BEQ/BNE/J redirects from execute, flushing the queue on any taken redirect.

## Interface
- WIDTH, 32: PC/address width; legal range 29..32.
- RESET_PC, 32'h00400000: PC loaded on reset; low two bits must be zero.
- DEPTH, 4: queue entries; power of two, at least 2.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  WIDTH  fetch address (the current PC); instruction memory returns data in the same cycle.
- imem_data  in  32  instruction word at imem_addr.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction; 0 when empty.
- out_pc  out  WIDTH  head PC; 0 when empty.
- fill  out  $clog2(DEPTH)+1  occupied entries.
- redir_valid  in  1  execute presents a resolved control-flow instruction.
- redir_branch, redir_jump, redir_zero, redir_invertzero  in  1 each  control bits and ALU zero for that instruction.
- redir_imm  in  16  branch offset field.
- redir_target  in  26  jump index field.
- redir_pc  in  WIDTH  PC of the resolving instruction.
- halted  out  1  fetch stopped on a zero word (see Configuration).

## Operation
- States: RUN (fetch enabled), FULL (fill==DEPTH and no pop), HALTED.
- Fetch: in RUN, when fill<DEPTH or a pop occurs in the same cycle, enqueue {imem_addr, imem_data} and set PC <= PC+4. PC arithmetic wraps modulo 2^WIDTH.
- Pop: the head is dequeued when out_valid && out_ready. A simultaneous push and pop at DEPTH keeps fill at DEPTH. A simultaneous push and pop at fill 0 is not possible, because out_valid is 0.
- Redirect taken = redir_valid && (redir_jump || (redir_branch && (redir_zero ^ redir_invertzero))).
  - pc4 = redir_pc+4.
  - Branch target = pc4 + (sign_extend(redir_imm)<<2).
  - Jump target = {pc4[WIDTH-1:28], redir_target, 2'b00}.
  - If redir_jump and redir_branch are both set, jump wins.
- Taken redirect has top priority:
  - Queue flushed (fill <= 0) and PC <= target.
  - Any fetch in that cycle is discarded.
  - A pop in the same cycle completes normally for the consumer.
  - Clears HALTED and returns the block to RUN.
- A not-taken redirect, or redir_valid low, has no effect.
- Reset outputs: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fill=0, halted=0; state RUN.
- Reset while a redirect is present: reset wins.

## Timing
- Cycle 0 after reset deassert: imem_addr=RESET_PC and the word is enqueued at the end of the cycle. Cycle 1: out_valid=1 with out_pc=RESET_PC.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction/cycle with out_ready held high.
- Redirect asserted in cycle N: imem_addr=target in cycle N+1, and the target instruction appears on out in cycle N+2. out_valid=0 in cycle N+1.
- FULL: PC holds and imem_addr is stable until a pop frees a slot.
- Outputs are registered or derived only from the queue and PC. There is no combinational path from out_ready or redir_* to imem_addr.

## Configuration
- HALT_ON_ZERO_EN defined: a fetched imem_data==32'h0 is not enqueued. PC holds, halted goes to 1 in the next cycle, and the state becomes HALTED. Entries already queued still drain. Only reset or a taken redirect leaves HALTED.
- HALT_ON_ZERO_EN undefined: zero words are treated as ordinary instructions (sll nop) and enqueued. halted is tied to 0.

## Test plan
- Reset then out_ready=1 with sequential memory → out_pc = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles starting at cycle 1.
- out_ready=0 for 10 cycles, DEPTH=4 → fill saturates at 4, imem_addr holds at 0x00400010. Raise out_ready → outputs drain in order with no loss or duplication.
- BNE at redir_pc=0x00400008, imm=16'hFFFE, zero=0, invertzero=1 → flush, imem_addr=0x00400004 next cycle, out_pc=0x00400004 two cycles later.
- J with redir_target=26'h0100010 at redir_pc=0x00400000 → PC=0x00400040. A redirect with branch=1, zero=1, invertzero=1 is not taken: no flush.
- HALT_ON_ZERO_EN defined, memory word 0 at 0x0040000C → three instructions delivered, then out_valid=0 and halted=1. A taken redirect clears halted and fetch resumes at the target. With the macro undefined, the zero word is delivered at out_pc=0x0040000C.
- Assert reset with fill=3 mid-stream → next cycle fill=0, out_valid=0, imem_addr=0x00400000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: instruction memory port, decode-side queue handshake and execute redirect.
interface fetch_unit_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int FW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] imem_addr;
   logic [31:0]      imem_data;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [WIDTH-1:0] out_pc;
   logic [FW-1:0]    fill;

   logic             redir_valid;
   logic             redir_branch;
   logic             redir_jump;
   logic             redir_zero;
   logic             redir_invertzero;
   logic [15:0]      redir_imm;
   logic [25:0]      redir_target;
   logic [WIDTH-1:0] redir_pc;

   logic             halted;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc, fill, halted,
      input  imem_data, out_ready, redir_valid, redir_branch, redir_jump,
             redir_zero, redir_invertzero, redir_imm, redir_target, redir_pc
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc, fill, halted,
      output imem_data, out_ready, redir_valid, redir_branch, redir_jump,
             redir_zero, redir_invertzero, redir_imm, redir_target, redir_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, DEPTH-entry fetch queue, BEQ/BNE/J redirect with flush.
// Fetch-to-output latency 1 cycle; PC stalls while the queue is full. HALT_ON_ZERO_EN stops fetch on a zero word.
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h00400000,
   parameter int               DEPTH    = 4
) (
   input  logic          clock,
   input  logic          reset,
   fetch_unit_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   typedef enum logic [1:0] {RUN, FULL, HALTED} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]    fill_q, fill_d;

   logic [31:0]      instr_mem [DEPTH];
   logic [WIDTH-1:0] pc_mem    [DEPTH];

   logic             taken;
   logic             pop;
   logic             fetch_en;
   logic             halt_hit;
   logic             push;
   logic [WIDTH-1:0] pc4;
   logic [WIDTH-1:0] br_tgt;
   logic [WIDTH-1:0] j_tgt;
   logic [WIDTH-1:0] tgt;

   always_comb begin
      pc4    = bus.redir_pc + WIDTH'(4);
      br_tgt = pc4 + {{(WIDTH-18){bus.redir_imm[15]}}, bus.redir_imm, 2'b00};
      j_tgt  = {pc4[WIDTH-1:28], bus.redir_target, 2'b00};
      tgt    = bus.redir_jump ? j_tgt : br_tgt;
      taken  = bus.redir_valid &&
               (bus.redir_jump || (bus.redir_branch && (bus.redir_zero ^ bus.redir_invertzero)));
   end

   assign pop      = (fill_q != '0) && bus.out_ready;
   assign fetch_en = (state_q != HALTED) && ((fill_q != FW'(DEPTH)) || pop);

`ifdef HALT_ON_ZERO_EN
   assign halt_hit = fetch_en && (bus.imem_data == 32'h0);
`else
   assign halt_hit = 1'b0;
`endif

   // A taken redirect discards whatever was fetched this cycle.
   assign push = fetch_en && !halt_hit && !taken;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;

      if (taken) begin
         pc_d     = tgt;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         fill_d   = '0;
         state_d  = RUN;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push) begin
            pc_d     = pc_q + WIDTH'(4);
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         fill_d = fill_q + FW'(push) - FW'(pop);
         if (halt_hit || (state_q == HALTED)) begin
            state_d = HALTED;
         end else if (fill_d == FW'(DEPTH)) begin
            state_d = FULL;
         end else begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
      end
   end

   // Storage needs no reset: outputs are gated by fill_q.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= bus.imem_data;
         pc_mem[wr_ptr_q]    <= pc_q;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = (fill_q != '0);
   assign bus.out_instr = (fill_q != '0) ? instr_mem[rd_ptr_q] : 32'h0;
   assign bus.out_pc    = (fill_q != '0) ? pc_mem[rd_ptr_q] : '0;
   assign bus.fill      = fill_q;

`ifdef HALT_ON_ZERO_EN
   assign bus.halted = (state_q == HALTED);
`else
   assign bus.halted = 1'b0;
`endif

endmodule
